// File: rtl/avalon_uart_pkg.sv
// Shared definitions for the Avalon-MM UART transmitter.
//   - register word offsets (decoded from av_address[2])
//   - STATUS bit positions and the STATUS write flush bit
//   - TX serialiser state encoding
//   - helper that packs the STATUS word
package avalon_uart_pkg;

    localparam int unsigned OFF_DATA       = 0;
    localparam int unsigned OFF_STATUS     = 1;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_BUSY      = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    localparam int unsigned FLUSH_BIT      = 31;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // STATUS = {16'b0, count[7:0], 5'b0, busy, empty, full}
    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       busy,
                                                input logic       empty,
                                                input logic       full);
        logic [31:0] w;
        w                          = '0;
        w[STAT_COUNT_LSB +: 8]     = count;
        w[STAT_BUSY]               = busy;
        w[STAT_EMPTY]              = empty;
        w[STAT_FULL]               = full;
        return w;
    endfunction

endpackage

// File: rtl/avalon_uart_tx_slave_sync_fifo.sv
// Synchronous FIFO with flush.
//   clock, reset : single clock, asynchronous active-high reset
//   flush        : drop all stored entries (takes priority over push/pop)
//   push, wdata  : write an entry; ignored while full
//   pop, rdata   : rdata shows the head entry; pop ignored while empty
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/avalon_uart_tx_slave.sv
// Avalon-MM slave: console TX UART (8N1) behind a TX FIFO.
//   clock, reset     : single clock, asynchronous active-high reset
//   av_address       : only bit [2] decoded (0 = DATA, 1 = STATUS)
//   av_read_n        : active-low read strobe (fixed one wait-state read)
//   av_write_n       : active-low write strobe
//   av_writedata     : DATA uses [7:0]; STATUS write with [31]=1 flushes the FIFO
//   av_readdata      : registered read data
//   av_waitrequest   : hold request (FIFO full on DATA write, or first read cycle)
//   tx               : serial line, idle high
//   tx_busy          : frame on the line or bytes still queued
module avalon_uart_tx_slave
    import avalon_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read_n,
    input  logic              av_write_n,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic              tx,
    output logic              tx_busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] BAUD_ONE    = 16'd1;

    // Avalon decode
    logic wr;
    logic rd;
    logic sel_status;
    logic rd_pend;
    logic push;
    logic flush;

    // FIFO interface
    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Serialiser
    tx_state_e  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        baud_done;

    logic unused_bits;
    assign unused_bits = ^{av_address[ADDR_W-1:3], av_address[1:0], av_writedata[30:8]};

    assign wr         = ~av_write_n;
    // A simultaneous write wins; the read is dropped entirely.
    assign rd         = ~av_read_n & av_write_n;
    assign sel_status = (av_address[2] == OFF_STATUS[0]);
    assign push       = wr & ~sel_status & ~fifo_full;
    assign flush      = wr & sel_status & av_writedata[FLUSH_BIT];

    assign av_waitrequest = ~reset & ((wr & ~sel_status & fifo_full) | (rd & ~rd_pend));
    assign tx_busy        = (state_q != StIdle) | ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (av_writedata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Read path: first cycle captures data and raises rd_pend, second completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend     <= 1'b0;
            av_readdata <= '0;
        end else if (rd && !rd_pend) begin
            rd_pend     <= 1'b1;
            av_readdata <= sel_status ?
                           status_word(8'(fifo_count), tx_busy, fifo_empty, fifo_full) : '0;
        end else begin
            rd_pend     <= 1'b0;
        end
    end

    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        if (state_q != StIdle && !baud_done) begin
            baud_d = baud_q - BAUD_ONE;
        end

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = BAUD_RELOAD;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    baud_d  = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        baud_d   = BAUD_RELOAD;
                        state_d  = StStart;
                    end else begin
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_avalon_uart_tx_slave.sv
module tb_avalon_uart_tx_slave;

    localparam int unsigned BAUD  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * BAUD;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] av_address = BASE;
    logic        av_read_n = 1'b1;
    logic        av_write_n = 1'b1;
    logic [31:0] av_writedata = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts_q[$];

    avalon_uart_tx_slave #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .av_address     (av_address),
        .av_read_n      (av_read_n),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .tx             (tx),
        .tx_busy        (tx_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line monitor: decodes 8N1 frames at mid-bit and pops the scoreboard.
    logic       mon_busy = 1'b0;
    int         mon_t = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] mon_exp;

    always @(negedge clock) begin
        if (reset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy  = 1'b1;
                mon_t     = 0;
                mon_start = cyc;
                mon_byte  = '0;
            end
        end else begin
            mon_t++;
            if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % 4) == 0) begin
                mon_byte[(mon_t - 6) / 4] = tx;
            end
            if (mon_t == 38) begin
                check("stop_bit", {31'b0, tx}, 32'd1);
            end
            if (mon_t == 39) begin
                mon_busy = 1'b0;
                starts_q.push_back(mon_start);
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("sb_frame", {24'b0, mon_byte}, {24'b0, mon_exp});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic avs_write(input logic sel, input logic [31:0] data, output int waits);
        av_address   = sel ? (BASE | 32'h4) : BASE;
        av_writedata = data;
        av_write_n   = 1'b0;
        waits        = 0;
        @(negedge clock);
        while (av_waitrequest && waits < 200) begin
            waits++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        av_write_n = 1'b1;
    endtask

    task automatic avs_read(input logic sel, output logic [31:0] data, output int waits);
        av_address = sel ? (BASE | 32'h4) : BASE;
        av_read_n  = 1'b0;
        waits      = 0;
        @(negedge clock);
        while (av_waitrequest && waits < 10) begin
            waits++;
            @(negedge clock);
        end
        data = av_readdata;
        @(posedge clock);
        #1;
        av_read_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, output int fall_cyc);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || mon_busy) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        fall_cyc = cyc;
        check(tag, {31'b0, tx_busy}, 32'd0);
        step(1);
    endtask

    initial begin
        int          w;
        int          fall;
        int          low_seen;
        logic [31:0] d;
        logic [7:0]  b;
        logic        e;

        // Reset state
        @(posedge clock);
        #2;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_readdata", av_readdata, 32'd0);
        check("rst_wait", {31'b0, av_waitrequest}, 32'd0);
        check("rst_busy", {31'b0, tx_busy}, 32'd0);
        step(1);
        reset = 1'b0;
        step(2);

        // 1: single byte, exact waveform
        b = 8'h55;
        avs_write(1'b0, {24'b0, b}, w);
        exp_q.push_back(b);
        check("t1_wait", w, 0);
        for (int n = 0; n < 42; n++) begin
            @(negedge clock);
            if (n == 0 || n >= 37)  e = 1'b1;
            else if (n <= 4)        e = 1'b0;
            else                    e = b[(n - 5) / 4];
            check($sformatf("t1_tx_%0d", n), {31'b0, tx}, {31'b0, e});
        end
        check("t1_busy_end", {31'b0, tx_busy}, 32'd0);
        step(1);
        wait_idle("t1_idle", fall);

        // 2: fill past capacity; first byte leaves the FIFO at once, so the sixth stalls
        starts_q.delete();
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            avs_write(1'b0, {24'b0, b}, w);
            exp_q.push_back(b);
            check($sformatf("t2_wait%0d", i), w, (i == 6) ? 37 : 0);
        end
        wait_idle("t2_idle", fall);
        check("t2_frames", starts_q.size(), 6);
        for (int i = 1; i < 6 && i < starts_q.size(); i++) begin
            check($sformatf("t2_gap%0d", i), starts_q[i] - starts_q[i-1], FRAME);
        end

        // 3: STATUS read with three bytes queued behind the one on the line
        for (int i = 0; i < 4; i++) begin
            b = 8'hA0 + 8'(i);
            avs_write(1'b0, {24'b0, b}, w);
            exp_q.push_back(b);
        end
        avs_read(1'b1, d, w);
        check("t3_rd_wait", w, 1);
        check("t3_status", d, 32'h0000_0304);
        step(40);
        avs_read(1'b1, d, w);
        check("t3_status_dec", d, 32'h0000_0204);
        avs_read(1'b0, d, w);
        check("t3_data_rd", d, 32'h0);
        wait_idle("t3_idle", fall);
        avs_read(1'b1, d, w);
        check("t3_status_idle", d, 32'h0000_0002);

        // 4: flush mid-frame
        starts_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'hB0 + 8'(i);
            avs_write(1'b0, {24'b0, b}, w);
            exp_q.push_back(b);
        end
        step(10);
        avs_write(1'b1, 32'h8000_0000, w);
        check("t4_flush_wait", w, 0);
        repeat (3) void'(exp_q.pop_back());
        avs_read(1'b1, d, w);
        check("t4_status", d, 32'h0000_0006);
        wait_idle("t4_idle", fall);
        check("t4_busy_fall", fall - ((starts_q.size() > 0) ? starts_q[0] : 0), FRAME);
        low_seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (tx !== 1'b1) low_seen++;
        end
        check("t4_line_quiet", low_seen, 0);
        check("t4_frames", starts_q.size(), 1);
        step(1);

        // 5: reset during data bit 3
        b = 8'hA5;
        avs_write(1'b0, {24'b0, b}, w);
        exp_q.push_back(b);
        repeat (18) @(negedge clock);
        check("t5_bit3", {31'b0, tx}, {31'b0, b[3]});
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_tx", {31'b0, tx}, 32'd1);
        check("t5_rst_busy", {31'b0, tx_busy}, 32'd0);
        check("t5_rst_wait", {31'b0, av_waitrequest}, 32'd0);
        exp_q.delete();
        step(2);
        reset = 1'b0;
        step(1);
        avs_read(1'b1, d, w);
        check("t5_status", d, 32'h0000_0002);
        check("t5_rd_wait", w, 1);
        b = 8'h3C;
        avs_write(1'b0, {24'b0, b}, w);
        exp_q.push_back(b);
        wait_idle("t5_idle", fall);

        // 6: read and write together; write wins, read leaves no trace
        av_address   = BASE;
        av_writedata = 32'h0000_0077;
        av_write_n   = 1'b0;
        av_read_n    = 1'b0;
        @(negedge clock);
        check("t6_wait", {31'b0, av_waitrequest}, 32'd0);
        @(posedge clock);
        #1;
        av_write_n = 1'b1;
        av_read_n  = 1'b1;
        exp_q.push_back(8'h77);
        check("t6_readdata_held", av_readdata, 32'h0000_0002);
        avs_read(1'b1, d, w);
        check("t6_next_rd_wait", w, 1);
        wait_idle("t6_idle", fall);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
